// File: rtl/bist_checker.sv
// LFSR-driven link checker: regenerates the expected channel pattern, compares it
// against the received channels and keeps sticky pass/fail statistics per run.
module bist_checker #(
  parameter int unsigned TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int unsigned TEST_CASES    = 1000,
  parameter int unsigned ERR_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     done,
  output logic                     failed,
  output logic [ERR_W-1:0]         error_count,
  output logic [TEST_CHANNELS-1:0] fail_mask,
  output logic [31:0]              first_fail_case,
  output logic [TEST_CHANNELS-1:0] output_channels
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int unsigned WARM_CYCLES = (TEST_CHANNELS + 31) / 32;
  localparam logic [5:0]  WARM_LAST   = 6'(WARM_CYCLES - 1);
  localparam logic [31:0] CASE_LAST   = 32'(TEST_CASES - 1);

  logic [1:0]               state_reg, state_next;
  logic [31:0]              lfsr_reg, lfsr_next, lfsr_step;
  logic [TEST_CHANNELS-1:0] expected_reg, expected_next, expected_shift;
  logic [31:0]              cases_reg, cases_next;
  logic [5:0]               warm_cnt_reg, warm_cnt_next;
  logic                     failed_reg, failed_next;
  logic [ERR_W-1:0]         error_count_reg, error_count_next;
  logic [TEST_CHANNELS-1:0] fail_mask_reg, fail_mask_next;
  logic [31:0]              first_fail_reg, first_fail_next;
  logic [TEST_CHANNELS-1:0] mismatch_vec;

  assign lfsr_step    = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
  assign mismatch_vec = input_channels ^ expected_reg;

  // Newest LFSR word enters at the bottom; older words shift up and fall off the top.
  generate
    if (TEST_CHANNELS > 32) begin : g_wide
      assign expected_shift = {expected_reg[TEST_CHANNELS-33:0], lfsr_reg};
    end else begin : g_narrow
      assign expected_shift = lfsr_reg[TEST_CHANNELS-1:0];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    lfsr_next        = lfsr_reg;
    expected_next    = expected_reg;
    cases_next       = cases_reg;
    warm_cnt_next    = warm_cnt_reg;
    failed_next      = failed_reg;
    error_count_next = error_count_reg;
    fail_mask_next   = fail_mask_reg;
    first_fail_next  = first_fail_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next       = WARMUP;
          lfsr_next        = SEED_EFF;
          expected_next    = '0;
          cases_next       = '0;
          warm_cnt_next    = '0;
          failed_next      = 1'b0;
          error_count_next = '0;
          fail_mask_next   = '0;
          first_fail_next  = '1;
        end
      end
      WARMUP: begin
        lfsr_next     = lfsr_step;
        expected_next = expected_shift;
        warm_cnt_next = warm_cnt_reg + 6'd1;
        if (warm_cnt_reg == WARM_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        lfsr_next     = lfsr_step;
        expected_next = expected_shift;
        cases_next    = cases_reg + 32'd1;
        if (|mismatch_vec) begin
          fail_mask_next = fail_mask_reg | mismatch_vec;
          failed_next    = 1'b1;
          if (error_count_reg != '1) begin
            error_count_next = error_count_reg + ERR_W'(1);
          end
          // failed_reg is still clear only before the first mismatch of this run.
          if (!failed_reg) begin
            first_fail_next = cases_reg;
          end
        end
        if (cases_reg == CASE_LAST) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      lfsr_reg        <= SEED_EFF;
      expected_reg    <= '0;
      cases_reg       <= '0;
      warm_cnt_reg    <= '0;
      failed_reg      <= 1'b0;
      error_count_reg <= '0;
      fail_mask_reg   <= '0;
      first_fail_reg  <= '1;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= lfsr_next;
      expected_reg    <= expected_next;
      cases_reg       <= cases_next;
      warm_cnt_reg    <= warm_cnt_next;
      failed_reg      <= failed_next;
      error_count_reg <= error_count_next;
      fail_mask_reg   <= fail_mask_next;
      first_fail_reg  <= first_fail_next;
    end
  end

  assign busy            = (state_reg == WARMUP) || (state_reg == RUN);
  assign done            = (state_reg == DONE);
  assign failed          = failed_reg;
  assign error_count     = error_count_reg;
  assign fail_mask       = fail_mask_reg;
  assign first_fail_case = first_fail_reg;
  // Traffic is only released downstream once the verdict is known or a failure was seen.
  assign output_channels = (done || failed_reg) ? input_channels : '0;

endmodule

// File: tb/tb_bist_checker.sv
// Directed bench for bist_checker: loopback runs against a reference generator,
// injected errors, ignored restarts, mid-run reset, saturation and a minimal config.
module tb_bist_checker;
  localparam int          TC   = 70;
  localparam logic [31:0] SEED = 32'hdeadbeef;
  localparam int          NONE = -1000;
  localparam logic [TC-1:0] PAT = 70'h3123456789abcdef0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          start;
  logic [TC-1:0] din;
  logic          busy, done, failed;
  logic [15:0]   error_count;
  logic [TC-1:0] fail_mask, dout;
  logic [31:0]   first_fail_case;

  logic          start_sat;
  logic [TC-1:0] din_sat;
  logic          busy_sat, done_sat, failed_sat;
  logic [3:0]    error_count_sat;
  logic [TC-1:0] fail_mask_sat, dout_sat;
  logic [31:0]   first_fail_sat;

  logic          start_small;
  logic [31:0]   din_small;
  logic          busy_small, done_small, failed_small;
  logic [15:0]   error_count_small;
  logic [31:0]   fail_mask_small, dout_small;
  logic [31:0]   first_fail_small;

  bist_checker dut (
    .clk(clk), .reset(reset), .start(start), .input_channels(din),
    .busy(busy), .done(done), .failed(failed), .error_count(error_count),
    .fail_mask(fail_mask), .first_fail_case(first_fail_case), .output_channels(dout)
  );

  bist_checker #(.ERR_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start_sat), .input_channels(din_sat),
    .busy(busy_sat), .done(done_sat), .failed(failed_sat), .error_count(error_count_sat),
    .fail_mask(fail_mask_sat), .first_fail_case(first_fail_sat), .output_channels(dout_sat)
  );

  bist_checker #(.TEST_CHANNELS(32), .TEST_CASES(1)) dut_small (
    .clk(clk), .reset(reset), .start(start_small), .input_channels(din_small),
    .busy(busy_small), .done(done_small), .failed(failed_small), .error_count(error_count_small),
    .fail_mask(fail_mask_small), .first_fail_case(first_fail_small), .output_channels(dout_small)
  );

  int compared = 0;
  int mismatched = 0;
  int busy_cycles;
  logic [31:0]   gl;
  logic [TC-1:0] ge;

  function automatic logic [31:0] step(input logic [31:0] n);
    return {n[30:0], n[31] ^ n[21] ^ n[1] ^ n[0]};
  endfunction

  task automatic chk(input string tag, input logic [TC-1:0] obs, input logic [TC-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gl = SEED;
    ge = '0;
    busy_cycles = 0;
  endtask

  // Reference generator drives the matching pattern; optional bit-5 error and start pulse.
  task automatic run_steps(input int n_steps, input int bad_case, input int restart_case);
    for (int i = 0; i < n_steps; i++) begin
      if (busy) busy_cycles++;
      din = ge;
      if (i == 3 + bad_case) begin
        din[5] = ~din[5];
        chk("failed_before_bad", {69'd0, failed}, 70'd0);
      end
      start = (i == 3 + restart_case);
      @(posedge clk); #1;
      start = 1'b0;
      ge = {ge[TC-33:0], gl};
      gl = step(gl);
      if (i == 3 + bad_case) chk("failed_after_bad", {69'd0, failed}, 70'd1);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; start_sat = 1'b0; start_small = 1'b0;
    din = PAT; din_sat = '0; din_small = '0;
    gl = SEED; ge = '0; busy_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {69'd0, busy}, 70'd0);
    chk("rst_done", {69'd0, done}, 70'd0);
    chk("rst_failed", {69'd0, failed}, 70'd0);
    chk("rst_errcnt", {54'd0, error_count}, 70'd0);
    chk("rst_mask", fail_mask, 70'd0);
    chk("rst_ffc", {38'd0, first_fail_case}, 70'hffffffff);
    chk("rst_out", dout, 70'd0);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {69'd0, busy}, 70'd0);
    chk("idle_out", dout, 70'd0);

    // Clean loopback pass
    launch();
    run_steps(1003, NONE, NONE);
    chk("clean_busy_cycles", 70'(busy_cycles), 70'd1003);
    chk("clean_done", {69'd0, done}, 70'd1);
    chk("clean_busy", {69'd0, busy}, 70'd0);
    chk("clean_failed", {69'd0, failed}, 70'd0);
    chk("clean_errcnt", {54'd0, error_count}, 70'd0);
    chk("clean_mask", fail_mask, 70'd0);
    chk("clean_ffc", {38'd0, first_fail_case}, 70'hffffffff);
    din = PAT;
    #1;
    chk("clean_out", dout, PAT);
    @(posedge clk); #1;
    chk("clean_hold_done", {69'd0, done}, 70'd1);

    // Single bit-5 error at case 10
    launch();
    run_steps(1003, 10, NONE);
    chk("err_done", {69'd0, done}, 70'd1);
    chk("err_failed", {69'd0, failed}, 70'd1);
    chk("err_errcnt", {54'd0, error_count}, 70'd1);
    chk("err_mask", fail_mask, 70'h20);
    chk("err_ffc", {38'd0, first_fail_case}, 70'd10);
    din = PAT;
    #1;
    chk("err_out", dout, PAT);

    // Start during RUN is ignored
    launch();
    run_steps(1003, NONE, 200);
    chk("restart_busy_cycles", 70'(busy_cycles), 70'd1003);
    chk("restart_done", {69'd0, done}, 70'd1);
    chk("restart_failed", {69'd0, failed}, 70'd0);

    // Reset at case 500 after an earlier error
    launch();
    run_steps(503, 50, NONE);
    chk("abort_pre_failed", {69'd0, failed}, 70'd1);
    chk("abort_pre_busy", {69'd0, busy}, 70'd1);
    din = PAT;
    reset = 1'b0;
    #1;
    chk("abort_busy", {69'd0, busy}, 70'd0);
    chk("abort_failed", {69'd0, failed}, 70'd0);
    chk("abort_errcnt", {54'd0, error_count}, 70'd0);
    chk("abort_mask", fail_mask, 70'd0);
    chk("abort_ffc", {38'd0, first_fail_case}, 70'hffffffff);
    chk("abort_out", dout, 70'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_idle_busy", {69'd0, busy}, 70'd0);
    chk("abort_idle_done", {69'd0, done}, 70'd0);
    chk("abort_idle_out", dout, 70'd0);
    launch();
    run_steps(1003, NONE, NONE);
    chk("rerun_busy_cycles", 70'(busy_cycles), 70'd1003);
    chk("rerun_done", {69'd0, done}, 70'd1);
    chk("rerun_failed", {69'd0, failed}, 70'd0);
    chk("rerun_errcnt", {54'd0, error_count}, 70'd0);

    // Saturating 4-bit error counter with input held low
    start_sat = 1'b1;
    @(posedge clk); #1;
    start_sat = 1'b0;
    for (int i = 0; i < 2000 && !done_sat; i++) begin
      @(posedge clk); #1;
    end
    chk("sat_done", {69'd0, done_sat}, 70'd1);
    chk("sat_failed", {69'd0, failed_sat}, 70'd1);
    chk("sat_errcnt", {66'd0, error_count_sat}, 70'd15);
    chk("sat_mask_nonzero", {69'd0, |fail_mask_sat}, 70'd1);
    chk("sat_ffc", {38'd0, first_fail_sat}, 70'd0);
    chk("sat_out", dout_sat, 70'd0);

    // 32 channels, one case: first RUN word is the seed itself
    din_small = 32'hdeadbeef;
    start_small = 1'b1;
    @(posedge clk); #1;
    start_small = 1'b0;
    chk("small_c1_busy", {69'd0, busy_small}, 70'd1);
    chk("small_c1_done", {69'd0, done_small}, 70'd0);
    @(posedge clk); #1;
    chk("small_c2_busy", {69'd0, busy_small}, 70'd1);
    chk("small_c2_done", {69'd0, done_small}, 70'd0);
    @(posedge clk); #1;
    chk("small_c3_done", {69'd0, done_small}, 70'd1);
    chk("small_c3_busy", {69'd0, busy_small}, 70'd0);
    chk("small_failed", {69'd0, failed_small}, 70'd0);
    chk("small_errcnt", {54'd0, error_count_small}, 70'd0);
    chk("small_mask", {38'd0, fail_mask_small}, 70'd0);
    chk("small_ffc", {38'd0, first_fail_small}, 70'hffffffff);
    chk("small_out", {38'd0, dout_small}, 70'hdeadbeef);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
